// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double dabble, one bit per cycle).
// Saturates to 9999 with ovf for inputs above 9999.
// Optional build macro BCD_BLANK_LEADING_ZEROS_EN: leading zero digits are
// replaced by the display blank code 4'hF (digit0 and saturated results never blanked).
module bin_to_bcd_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3
);

  localparam int unsigned BIN_W     = 14;
  localparam int unsigned BCD_W     = 16;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned NDIG      = 4;
  localparam int unsigned MAX_VAL   = 9999;
  localparam int unsigned LAST_ITER = BIN_W - 1;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   dig_q, dig_d;

  logic [BCD_W-1:0]   acc_adj;
  logic [BCD_W-1:0]   acc_step;
  logic [BIN_W-1:0]   shift_step;
  logic               unused_carry;
  logic [BCD_W-1:0]   fin;
  logic [BCD_W-1:0]   dig_final;

  // One double-dabble iteration: +3 on nibbles >= 5, then shift {acc, shift} left.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    {unused_carry, acc_step, shift_step} = {acc_adj, shift_q, 1'b0};
  end

  // Final digit values: saturation override, then optional leading-zero blanking.
  always_comb begin
    fin       = sat_q ? 16'h9999 : acc_step;
    dig_final = fin;
`ifdef BCD_BLANK_LEADING_ZEROS_EN
    if (fin[15:12] == 4'h0) begin
      dig_final[15:12] = 4'hF;
      if (fin[11:8] == 4'h0) begin
        dig_final[11:8] = 4'hF;
        if (fin[7:4] == 4'h0) begin
          dig_final[7:4] = 4'hF;
        end
      end
    end
`endif
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    dig_d   = dig_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = bin;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = (bin > BIN_W'(MAX_VAL));
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d   = acc_step;
        shift_d = shift_step;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LAST_ITER)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ovf_d   = sat_q;
          dig_d   = dig_final;
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      dig_q   <= dig_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign ovf    = ovf_q;
  assign digit0 = dig_q[3:0];
  assign digit1 = dig_q[7:4];
  assign digit2 = dig_q[11:8];
  assign digit3 = dig_q[15:12];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed cases plus random values
// checked against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [3:0]  digit0, digit1, digit2, digit3;

  int checks;
  int failures;

  logic [15:0] prev_dig;
  logic        prev_ovf;

  bin_to_bcd_seq dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .digit0 (digit0),
    .digit1 (digit1),
    .digit2 (digit2),
    .digit3 (digit3)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard time limit
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits of min(v, 9999), optionally blanking leading zeros.
  function automatic logic [15:0] model_digits(input int v);
    int  x;
    int  d [4];
    logic [15:0] r;
    x = (v > 9999) ? 9999 : v;
    d[0] = x % 10;
    d[1] = (x / 10) % 10;
    d[2] = (x / 100) % 10;
    d[3] = (x / 1000) % 10;
`ifdef BCD_BLANK_LEADING_ZEROS_EN
    if (x < 1000) d[3] = 15;
    if (x < 100)  d[2] = 15;
    if (x < 10)   d[1] = 15;
`endif
    r = {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])};
    return r;
  endfunction

  function automatic logic [15:0] out_digits();
    return {digit3, digit2, digit1, digit0};
  endfunction

  // One conversion started now (at a negedge); optional second start pulse with a
  // new bin at cycle inj; tail idle cycles after done are checked for silence.
  task automatic run_conv(input int v, input int inj, input int inj_val, input int tail);
    int ndone;
    ndone = 0;
    bin   = 14'(v);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_at_capture", 32'(busy), 32'd1);
    check("done_at_capture", 32'(done), 32'd0);
    for (int j = 1; j <= 14 + tail; j++) begin
      if (j == inj) begin
        start = 1'b1;
        bin   = 14'(inj_val);
      end
      @(negedge clock);
      if (j == inj) start = 1'b0;
      if (done) ndone++;
      if (j < 14) begin
        check("busy_conv", 32'(busy), 32'd1);
        check("done_conv", 32'(done), 32'd0);
        check("dig_hold", 32'(out_digits()), 32'(prev_dig));
        check("ovf_hold", 32'(ovf), 32'(prev_ovf));
      end else if (j == 14) begin
        check("done_pulse", 32'(done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        check("digits", 32'(out_digits()), 32'(model_digits(v)));
        check("ovf", 32'(ovf), 32'(v > 9999));
        prev_dig = model_digits(v);
        prev_ovf = (v > 9999);
      end else begin
        check("done_idle", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("dig_idle", 32'(out_digits()), 32'(prev_dig));
      end
    end
    check("done_count", 32'(ndone), 32'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    prev_dig = '0;
    prev_ovf = 1'b0;
    reset    = 1'b1;
    start    = 1'b1;
    bin      = 14'd1234;

    // Reset state, with start asserted to show reset priority
    repeat (2) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_digits", 32'(out_digits()), 32'd0);
    reset = 1'b0;
    start = 1'b0;

    // Directed values, first start in the cycle right after reset release
    run_conv(1234, 0, 0, 2);
    run_conv(0, 0, 0, 1);
    run_conv(42, 0, 0, 1);
    run_conv(9999, 0, 0, 1);
    run_conv(12000, 0, 0, 1);
    run_conv(7, 0, 0, 1);
    run_conv(16383, 0, 0, 0);
    run_conv(10000, 0, 0, 0);
    run_conv(5, 0, 0, 1);

    // Start pulse mid-conversion with changed bin is ignored
    run_conv(1234, 5, 5555, 16);

    // Start held high: back-to-back conversions every 15 cycles
    bin   = 14'd100;
    start = 1'b1;
    @(negedge clock);
    for (int n = 0; n < 4; n++) begin
      int cur;
      cur = (n % 2 == 0) ? 100 : 8765;
      bin = (n % 2 == 0) ? 14'd8765 : 14'd100;
      for (int j = 1; j <= 14; j++) begin
        @(negedge clock);
        if (j < 14) begin
          check("b2b_done_low", 32'(done), 32'd0);
        end else begin
          check("b2b_done", 32'(done), 32'd1);
          check("b2b_digits", 32'(out_digits()), 32'(model_digits(cur)));
          check("b2b_ovf", 32'(ovf), 32'd0);
        end
      end
      prev_dig = model_digits(cur);
      prev_ovf = 1'b0;
      if (n == 3) start = 1'b0;
      @(negedge clock);
      check("b2b_recapture", 32'(busy), (n < 3) ? 32'd1 : 32'd0);
    end

    // Reset at cycle 7 of a conversion aborts it
    run_conv(12000, 0, 0, 0);
    bin   = 14'd4321;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    check("abort_digits", 32'(out_digits()), 32'd0);
    prev_dig = '0;
    prev_ovf = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clock);
      check("abort_no_done", 32'(done), 32'd0);
    end
    run_conv(4321, 0, 0, 0);

    // Random values across the full 14-bit range and the valid range
    for (int i = 0; i < 40; i++) begin
      int v;
      v = (i % 2 == 0) ? int'($urandom_range(16383, 0)) : int'($urandom_range(9999, 0));
      run_conv(v, 0, 0, i % 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
